// File: rtl/wb_fabric_pkg.sv
// wb_fabric_pkg: shared types, constants and aperture decode for the fabric Wishbone controller.
package wb_fabric_pkg;

    typedef enum logic [1:0] {IDLE, ACTIVE, MISS, DONE} state_t;

    localparam int NUM_SLAVES = 4;
    localparam int SEL_W = 2;
    localparam logic [31:0] DEFAULT_READ_VALUE = 32'hBAD_FAB_AC;

    typedef struct packed {
        logic             hit;
        logic [SEL_W-1:0] idx;
    } dec_t;

    // Lowest-numbered enabled slave whose aperture matches wins
    function automatic dec_t decode(
        input logic [31:0]                  adr,
        input logic [NUM_SLAVES-1:0][31:0]  bases,
        input logic [NUM_SLAVES-1:0]        en,
        input int                           lsb
    );
        dec_t d;
        d = '0;
        for (int k = NUM_SLAVES - 1; k >= 0; k--)
            if (en[k] && (adr >> lsb) == (bases[k] >> lsb)) begin
                d.hit = 1'b1;
                d.idx = SEL_W'(k);
            end
        return d;
    endfunction

endpackage

// File: rtl/wb_fabric_arbiter_ctrl_if.sv
// wb_fabric_arbiter_ctrl_if: bridge-side and slave-side Wishbone signals plus error-log access.
interface wb_fabric_arbiter_ctrl_if #(parameter int AW = 17);
    import wb_fabric_pkg::*;

    logic [AW-1:0]              WBs_ADR_i;
    logic                       WBs_CYC_i;
    logic                       WBs_STB_i;
    logic [31:0]                WBs_DAT_o;
    logic                       WBs_ACK_o;
    logic [NUM_SLAVES-1:0]      WBs_CYC_s_o;
    logic [NUM_SLAVES-1:0]      WBs_ACK_s_i;
    logic [32*NUM_SLAVES-1:0]   WBs_DAT_s_i;
    logic                       Err_Clr_i;
    logic                       Bus_Err_o;
    logic [AW-1:0]              Err_Adr_o;
    logic [7:0]                 Err_Cnt_o;

    modport slave (
        input  WBs_ADR_i, WBs_CYC_i, WBs_STB_i, WBs_ACK_s_i, WBs_DAT_s_i, Err_Clr_i,
        output WBs_DAT_o, WBs_ACK_o, WBs_CYC_s_o, Bus_Err_o, Err_Adr_o, Err_Cnt_o
    );

    modport master (
        output WBs_ADR_i, WBs_CYC_i, WBs_STB_i, WBs_ACK_s_i, WBs_DAT_s_i, Err_Clr_i,
        input  WBs_DAT_o, WBs_ACK_o, WBs_CYC_s_o, Bus_Err_o, Err_Adr_o, Err_Cnt_o
    );

endinterface

// File: rtl/wb_fabric_err_log.sv
// wb_fabric_err_log: sticky bus-error flag, first-error address capture and saturating error count.
module wb_fabric_err_log #(
    parameter int AW = 17
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          err_i,
    input  logic [AW-1:0] adr_i,
    output logic          flag_o,
    output logic [AW-1:0] adr_o,
    output logic [7:0]    cnt_o
);

    logic          flag_q, flag_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [7:0]    cnt_q, cnt_d;

    // A new error beats a simultaneous clear
    always_comb begin
        flag_d = err_i | (flag_q & ~clr_i);
        adr_d  = (err_i && (!flag_q || clr_i)) ? adr_i : clr_i ? '0 : adr_q;
        cnt_d  = err_i ? (clr_i ? 8'd1 : cnt_q + {7'd0, cnt_q != 8'hFF}) : clr_i ? 8'd0 : cnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            flag_q <= 1'b0;
            adr_q  <= '0;
            cnt_q  <= '0;
        end else begin
            flag_q <= flag_d;
            adr_q  <= adr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign flag_o = flag_q;
    assign adr_o  = adr_q;
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/wb_fabric_arbiter_ctrl.sv
// wb_fabric_arbiter_ctrl: decodes bridge cycles onto one fabric slave, returns ACK/data,
// and terminates unmapped or silent accesses with a default value and an error log entry.
module wb_fabric_arbiter_ctrl #(
    parameter int                   APERWIDTH          = 17,
    parameter int                   APERSIZE           = 10,
    parameter logic [APERWIDTH-1:0] SLAVE_BASE_0       = 17'h00000,
    parameter logic [APERWIDTH-1:0] SLAVE_BASE_1       = 17'h04000,
    parameter logic [APERWIDTH-1:0] SLAVE_BASE_2       = 17'h05000,
    parameter logic [APERWIDTH-1:0] SLAVE_BASE_3       = 17'h06000,
    parameter logic [3:0]           SLAVE_EN           = 4'b0111,
    parameter int                   TIMEOUT_CYCLES     = 16,
    parameter logic [31:0]          DEFAULT_READ_VALUE = wb_fabric_pkg::DEFAULT_READ_VALUE
) (
    input  logic                    WBs_CLK_i,
    input  logic                    WBs_RST_i,
    wb_fabric_arbiter_ctrl_if.slave bus
);
    import wb_fabric_pkg::*;

    localparam logic [NUM_SLAVES-1:0][31:0] BASES = {
        32'(SLAVE_BASE_3), 32'(SLAVE_BASE_2), 32'(SLAVE_BASE_1), 32'(SLAVE_BASE_0)
    };

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [APERWIDTH-1:0] adr_q, adr_d;
    logic [7:0]           cnt_q, cnt_d;
    dec_t                 dec;
    logic                 active, ack_sel, timeout, err;

    assign dec     = decode(32'(bus.WBs_ADR_i), BASES, SLAVE_EN, APERSIZE + 2);
    assign active  = state_q == ACTIVE;
    assign ack_sel = bus.WBs_ACK_s_i[sel_q];
    assign timeout = cnt_q == 8'(TIMEOUT_CYCLES - 1);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        adr_d   = adr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (bus.WBs_CYC_i && bus.WBs_STB_i) begin
                adr_d   = bus.WBs_ADR_i;
                sel_d   = dec.idx;
                cnt_d   = '0;
                state_d = dec.hit ? ACTIVE : MISS;
            end
            ACTIVE: begin
                cnt_d   = cnt_q + 8'd1;
                state_d = !bus.WBs_CYC_i ? IDLE : (ack_sel || timeout) ? DONE : ACTIVE;
            end
            MISS:    state_d = bus.WBs_CYC_i ? DONE : IDLE;
            DONE:    state_d = bus.WBs_STB_i ? DONE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge WBs_CLK_i) begin
        if (WBs_RST_i) begin
            state_q <= IDLE;
            sel_q   <= '0;
            adr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.WBs_CYC_s_o = active ? NUM_SLAVES'(1) << sel_q : '0;
    assign bus.WBs_ACK_o   = bus.WBs_CYC_i & ((state_q == MISS) | (active & (ack_sel | timeout)));
    assign bus.WBs_DAT_o   = (active && ack_sel) ? bus.WBs_DAT_s_i[32*sel_q +: 32] : DEFAULT_READ_VALUE;
    // Any termination not carried by the selected slave's own ACK is a miss or timeout
    assign err             = bus.WBs_ACK_o & ~(active & ack_sel);

    wb_fabric_err_log #(.AW(APERWIDTH)) u_err_log (
        .clk_i  (WBs_CLK_i),
        .rst_i  (WBs_RST_i),
        .clr_i  (bus.Err_Clr_i),
        .err_i  (err),
        .adr_i  (adr_q),
        .flag_o (bus.Bus_Err_o),
        .adr_o  (bus.Err_Adr_o),
        .cnt_o  (bus.Err_Cnt_o)
    );

endmodule

// File: tb/tb_wb_fabric_arbiter_ctrl.sv
// tb_wb_fabric_arbiter_ctrl: transaction-level expectations compared every cycle, plus literal pins.
module tb_wb_fabric_arbiter_ctrl;

    localparam logic [31:0] DEF = 32'hBADFABAC;
    localparam int T = 16;
    localparam logic [16:0] BASE [4] = '{17'h00000, 17'h04000, 17'h05000, 17'h06000};
    localparam logic [3:0] EN = 4'b0111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_fabric_arbiter_ctrl_if #(.AW(17)) bus();

    wb_fabric_arbiter_ctrl dut (
        .WBs_CLK_i (clk),
        .WBs_RST_i (rst),
        .bus       (bus)
    );

    int          vectors = 0, miscompares = 0;
    bit          chk_en = 0, use_fixed = 0, rnd_clr = 0, clr_miss = 0, saw3 = 0;
    logic [3:0]  exp_cyc_s = '0;
    logic        exp_ack = 1'b0;
    logic [31:0] exp_dat = DEF, fixed_dat = '0, last_dat = '0;
    bit          ef = 0;
    logic [16:0] ea_m = '0;
    int          ec = 0, cyc_n = 0, t0 = 0, ack_at = -1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc_n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_s", 32'(bus.WBs_CYC_s_o), 32'(exp_cyc_s));
            chk("ack", 32'(bus.WBs_ACK_o), 32'(exp_ack));
            chk("dat", bus.WBs_DAT_o, exp_dat);
            chk("bus_err", 32'(bus.Bus_Err_o), 32'(ef));
            chk("err_adr", 32'(bus.Err_Adr_o), 32'(ea_m));
            chk("err_cnt", 32'(bus.Err_Cnt_o), 32'(ec));
            if (bus.WBs_ACK_o === 1'b1) begin
                ack_at   = cyc_n - t0;
                last_dat = bus.WBs_DAT_o;
            end
            saw3 = saw3 | (bus.WBs_CYC_s_o[3] === 1'b1);
        end
    end

    function automatic int tgt(input logic [16:0] a);
        for (int k = 0; k < 4; k++)
            if (EN[k] && a[16:12] == BASE[k][16:12]) return k;
        return -1;
    endfunction

    // Bridge and slave stimulus for one cycle; other slaves ACK at random and must be ignored
    task automatic drv(input bit cyc, input bit stb, input int k, input bit ack_k);
        logic [3:0] m;
        m = (k >= 0) ? 4'(1 << k) : 4'b0;
        bus.WBs_CYC_i   = cyc;
        bus.WBs_STB_i   = stb;
        bus.WBs_DAT_s_i = use_fixed ? {4{fixed_dat}} : {$urandom, $urandom, $urandom, $urandom};
        bus.WBs_ACK_s_i = (4'($urandom) & ~m) | (ack_k ? m : 4'b0);
        bus.Err_Clr_i   = rnd_clr && ($urandom_range(0, 15) == 0);
    endtask

    task automatic idle_exp();
        exp_cyc_s = '0;
        exp_ack   = 1'b0;
        exp_dat   = DEF;
    endtask

    // Error-log model: outputs reflect the cycle's event after the edge
    task automatic step(input bit ev, input logic [16:0] ea);
        @(posedge clk);
        if (rst) begin
            ef = 0; ea_m = '0; ec = 0;
        end else if (ev) begin
            if (!ef || bus.Err_Clr_i) ea_m = ea;
            ef = 1;
            ec = bus.Err_Clr_i ? 1 : (ec < 255 ? ec + 1 : 255);
        end else if (bus.Err_Clr_i) begin
            ef = 0; ea_m = '0; ec = 0;
        end
        cyc_n++;
        #1;
    endtask

    // One transfer: slave ACK at cycle ack_c (0 = never), abort or reset at stop_c, STB held hold cycles
    task automatic txn(input logic [16:0] a, input int ack_c, input int stop_c, input bit stop_rst, input int hold);
        int k;
        bit stopped, ak;
        k = tgt(a);
        stopped = 0;
        ack_at = -1;
        t0 = cyc_n;
        bus.WBs_ADR_i = a;
        drv(1, 1, -1, 0);
        idle_exp();
        step(0, a);
        if (k < 0) begin
            drv(1, 1, -1, 0);
            if (clr_miss) bus.Err_Clr_i = 1'b1;
            exp_ack = 1'b1;
            step(1, a);
        end else begin
            for (int c = 1; c <= T; c++) begin
                stopped   = (c == stop_c);
                ak        = (c == ack_c) && !stopped;
                drv(!(stopped && !stop_rst), 1, k, ak);
                rst       = stopped && stop_rst;
                exp_cyc_s = 4'(1 << k);
                exp_ack   = !(stopped && !stop_rst) && (ak || c == T);
                exp_dat   = ak ? bus.WBs_DAT_s_i[32*k +: 32] : DEF;
                step(exp_ack && !ak, a);
                if (exp_ack || stopped) break;
            end
        end
        rst = 1'b0;
        idle_exp();
        if (!stopped) begin
            for (int h = 0; h < hold; h++) begin
                drv(1, 1, k, 1'($urandom_range(0, 1)));
                step(0, a);
            end
        end
        drv(0, 0, -1, 0);
        step(0, a);
    endtask

    initial begin
        int r;
        logic [16:0] a;
        bus.WBs_ADR_i = '0;
        drv(0, 0, -1, 0);
        @(posedge clk);
        #1;
        chk_en = 1;
        step(0, '0);
        step(0, '0);
        rst = 1'b0;
        chk("rst_flag", 32'(bus.Bus_Err_o), 32'd0);
        chk("rst_cnt", 32'(bus.Err_Cnt_o), 32'd0);
        chk("rst_dat", bus.WBs_DAT_o, 32'hBADFABAC);

        use_fixed = 1;
        fixed_dat = 32'h0000_0100;
        txn(17'h00004, 2, 0, 0, 0);
        chk("s0_ack_cycle", 32'(ack_at), 32'd2);
        chk("s0_data", last_dat, 32'h0000_0100);
        chk("s0_no_err", 32'(bus.Bus_Err_o), 32'd0);

        txn(17'h08000, 0, 0, 0, 1);
        chk("miss_ack_cycle", 32'(ack_at), 32'd1);
        chk("miss_data", last_dat, 32'hBADFABAC);
        chk("miss_flag", 32'(bus.Bus_Err_o), 32'd1);
        chk("miss_adr", 32'(bus.Err_Adr_o), 32'h08000);
        chk("miss_cnt", 32'(bus.Err_Cnt_o), 32'd1);

        saw3 = 0;
        txn(17'h06000, 0, 0, 0, 0);
        chk("s3_never_selected", 32'(saw3), 32'd0);
        chk("s3_cnt", 32'(bus.Err_Cnt_o), 32'd2);
        chk("s3_adr_kept", 32'(bus.Err_Adr_o), 32'h08000);

        txn(17'h04010, 0, 0, 0, 2);
        chk("to_ack_cycle", 32'(ack_at), 32'd16);
        chk("to_data", last_dat, 32'hBADFABAC);
        chk("to_cnt", 32'(bus.Err_Cnt_o), 32'd3);

        txn(17'h04020, 16, 0, 0, 0);
        chk("late_ack_cycle", 32'(ack_at), 32'd16);
        chk("late_data", last_dat, 32'h0000_0100);
        chk("late_cnt", 32'(bus.Err_Cnt_o), 32'd3);

        txn(17'h05000, 0, 3, 0, 0);
        chk("abort_no_ack", 32'(ack_at), 32'hFFFF_FFFF);
        chk("abort_cnt", 32'(bus.Err_Cnt_o), 32'd3);

        txn(17'h00040, 0, 2, 1, 0);
        chk("rst_mid_flag", 32'(bus.Bus_Err_o), 32'd0);
        chk("rst_mid_cnt", 32'(bus.Err_Cnt_o), 32'd0);
        chk("rst_mid_adr", 32'(bus.Err_Adr_o), 32'd0);

        for (int i = 0; i < 300; i++) txn(17'h04000 + 17'(4 * (i % 1024)), 0, 0, 0, 0);
        chk("sat_cnt", 32'(bus.Err_Cnt_o), 32'd255);
        chk("sat_first_adr", 32'(bus.Err_Adr_o), 32'h04000);

        clr_miss = 1;
        txn(17'h0A000, 0, 0, 0, 0);
        clr_miss = 0;
        chk("clr_err_cnt", 32'(bus.Err_Cnt_o), 32'd1);
        chk("clr_err_adr", 32'(bus.Err_Adr_o), 32'h0A000);
        chk("clr_err_flag", 32'(bus.Bus_Err_o), 32'd1);

        use_fixed = 0;
        rnd_clr = 1;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 5);
            a = (r < 4) ? (BASE[r] | 17'($urandom_range(0, 4095))) : 17'($urandom);
            txn(a, $urandom_range(0, 20),
                ($urandom_range(0, 7) == 0) ? $urandom_range(1, 5) : 0,
                1'($urandom_range(0, 2) == 0), $urandom_range(0, 2));
        end

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
